// File: rtl/multicycle_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_ctrl: RV32I multi-cycle control FSM with instret and trap.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module multicycle_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [4:0]       rd,
  input  logic             br_cond,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_we,
  output logic [3:0]       alu_op,
  output logic             alu_src_b,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             trap,
  output logic [1:0]       trap_cause
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM    = 2'd2;
  localparam logic [1:0] CAUSE_DMEM    = 2'd3;

  // Counter only needs to reach MEM_TIMEOUT-1: the last waiting cycle trips the trap.
  localparam int            TW      = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam bit            TO_EN   = (MEM_TIMEOUT > 0);

  state_t           r_state;
  state_t           w_state_next;
  logic [TW-1:0]    r_wait_cnt;
  logic [CNT_W-1:0] r_instret;
  logic             r_trap;
  logic [1:0]       r_trap_cause;
  logic             w_set_trap;
  logic [1:0]       w_cause_next;
  logic             w_timeout;
  logic             w_waiting;
  logic [3:0]       w_alu_fn;

  logic w_is_r, w_is_i, w_is_load, w_is_store, w_is_branch, w_is_jal, w_is_jalr, w_is_lui;
  logic w_legal;

  assign w_is_r      = (opcode == OP_R);
  assign w_is_i      = (opcode == OP_I);
  assign w_is_load   = (opcode == OP_LOAD);
  assign w_is_store  = (opcode == OP_STORE);
  assign w_is_branch = (opcode == OP_BRANCH);
  assign w_is_jal    = (opcode == OP_JAL);
  assign w_is_jalr   = (opcode == OP_JALR);
  assign w_is_lui    = (opcode == OP_LUI);
  assign w_legal     = w_is_r | w_is_i | w_is_load | w_is_store | w_is_branch
                     | w_is_jal | w_is_jalr;

  assign w_timeout = TO_EN && (r_wait_cnt == TO_LAST);
  assign w_waiting = ((r_state == S_FETCH) && !imem_ack) || ((r_state == S_MEM) && !dmem_ack);

  // Arithmetic/logic selection shared by register and immediate forms.
  always_comb begin
    w_alu_fn = ALU_ADD;
    case (funct3)
      3'b000:  w_alu_fn = (w_is_r && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  w_alu_fn = ALU_SLL;
      3'b010:  w_alu_fn = ALU_SLT;
      3'b011:  w_alu_fn = ALU_SLTU;
      3'b100:  w_alu_fn = ALU_XOR;
      3'b101:  w_alu_fn = funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  w_alu_fn = ALU_OR;
      default: w_alu_fn = ALU_AND;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_set_trap   = 1'b0;
    w_cause_next = 2'd0;
    imem_req     = 1'b0;
    ir_we        = 1'b0;
    alu_op       = ALU_ADD;
    alu_src_b    = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = 2'd0;
    pc_we        = 1'b0;
    pc_sel       = 2'd0;
    retire       = 1'b0;
    case (r_state)
      S_IDLE: w_state_next = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we        = 1'b1;
          w_state_next = S_DECODE;
        end else if (w_timeout) begin
          w_state_next = S_HALT;
          w_set_trap   = 1'b1;
          w_cause_next = CAUSE_IMEM;
        end
      end
      S_DECODE: begin
        if (w_is_lui) begin
          w_state_next = S_WB;
        end else if (w_legal) begin
          w_state_next = S_EXEC;
        end else begin
          w_state_next = S_HALT;
          w_set_trap   = 1'b1;
          w_cause_next = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        alu_src_b = !(w_is_r || w_is_branch);
        if (w_is_r || w_is_i) begin
          alu_op = w_alu_fn;
        end else if (w_is_branch) begin
          alu_op = ALU_SUB;
        end
        if (w_is_branch) begin
          pc_we        = 1'b1;
          pc_sel       = br_cond ? 2'd1 : 2'd0;
          retire       = 1'b1;
          w_state_next = S_FETCH;
        end else if (w_is_load || w_is_store) begin
          w_state_next = S_MEM;
        end else begin
          w_state_next = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = w_is_store;
        if (dmem_ack) begin
          if (w_is_store) begin
            pc_we        = 1'b1;
            retire       = 1'b1;
            w_state_next = S_FETCH;
          end else begin
            w_state_next = S_WB;
          end
        end else if (w_timeout) begin
          w_state_next = S_HALT;
          w_set_trap   = 1'b1;
          w_cause_next = CAUSE_DMEM;
        end
      end
      S_WB: begin
        rf_we  = (rd != 5'd0);
        pc_we  = 1'b1;
        retire = 1'b1;
        if (w_is_load) begin
          wb_sel = 2'd1;
        end else if (w_is_jal || w_is_jalr) begin
          wb_sel = 2'd2;
        end else if (w_is_lui) begin
          wb_sel = 2'd3;
        end
        if (w_is_jal) begin
          pc_sel = 2'd1;
        end else if (w_is_jalr) begin
          pc_sel = 2'd2;
        end
        w_state_next = S_FETCH;
      end
      S_HALT: w_state_next = S_HALT;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= '0;
      r_instret    <= '0;
      r_trap       <= 1'b0;
      r_trap_cause <= 2'd0;
    end else begin
      r_state <= w_state_next;
      if (w_waiting && (w_state_next == r_state)) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
      if (retire) begin
        r_instret <= r_instret + 1'b1;
      end
      if (w_set_trap) begin
        r_trap       <= 1'b1;
        r_trap_cause <= w_cause_next;
      end
    end
  end

  assign instret    = r_instret;
  assign trap       = r_trap;
  assign trap_cause = r_trap_cause;

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core.
- Consumes the field outputs of the instruction decoder and sequences the datapath: fetch handshake, IR load, ALU configuration, data-memory handshake, register write-back and PC update.
- Executes one instruction at a time.
- Also holds a retired-instruction counter and a sticky trap flag for illegal opcodes and memory timeouts.

Parameters:
- CNT_W, 32, width of instret counter.
- MEM_TIMEOUT, 255, max cycles waiting for imem_ack/dmem_ack before trapping; 0 disables timeout.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  7  from decoder (IR bits 6:0)
- funct3  in  3  from decoder
- funct7  in  7  from decoder
- rd  in  5  from decoder
- br_cond  in  1  branch comparator result, valid in EXEC
- imem_req  out  1  fetch request
- imem_ack  in  1  fetch data valid
- ir_we  out  1  load instruction register
- alu_op  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU
- alu_src_b  out  1  0 = rs2, 1 = immediate
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store (valid with dmem_req)
- dmem_ack  in  1  data access complete
- rf_we  out  1  register file write enable
- wb_sel  out  2  0 ALU, 1 MEM, 2 PC+4, 3 IMM (LUI)
- pc_we  out  1  PC update
- pc_sel  out  2  0 PC+4, 1 branch/JAL target, 2 JALR target
- retire  out  1  one-cycle pulse per completed instruction
- instret  out  CNT_W  retired-instruction count
- trap  out  1  sticky; FSM halted
- trap_cause  out  2  0 none, 1 illegal opcode, 2 imem timeout, 3 dmem timeout

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. State register is reset asynchronously.
- Reset: state = IDLE, instret = 0, trap = 0, trap_cause = 0. All outputs are 0 while rst is high and in IDLE.
- Reset asserted mid-instruction aborts it: no retire, no pc_we.
- IDLE -> FETCH unconditionally, one cycle after reset release.
- FETCH:
  - imem_req = 1 until imem_ack.
  - On the ack cycle: ir_we = 1 and next state = DECODE.
  - Timeout counter (MEM_TIMEOUT) starts on entry to FETCH or MEM and clears on ack. On reaching MEM_TIMEOUT without ack: HALT with the matching cause.
- DECODE (one cycle) dispatches on opcode:
  - 0110011 R-type, 0010011 I-type, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL, 1100111 JALR -> EXEC.
  - 0110111 LUI -> WB.
  - Any other opcode -> HALT, cause 1.
- EXEC (one cycle):
  - alu_src_b = 0 for R-type and BRANCH; 1 otherwise.
  - alu_op is derived from funct3 for R/I types:
    - 000 -> ADD, or SUB when R-type and funct7[5] = 1.
    - 001 -> SLL.
    - 010 -> SLT.
    - 011 -> SLTU.
    - 100 -> XOR.
    - 101 -> SRA when funct7[5] = 1, else SRL (applies to I-type too).
    - 110 -> OR.
    - 111 -> AND.
  - alu_op = ADD for LOAD, STORE, JAL, JALR; SUB for BRANCH.
  - BRANCH: pc_we = 1, pc_sel = br_cond ? 1 : 0, retire = 1, next state FETCH.
  - LOAD/STORE -> MEM. All other types -> WB.
- MEM:
  - dmem_req = 1; dmem_we = 1 for STORE only. Held until dmem_ack.
  - On ack: LOAD -> WB. STORE -> FETCH, with pc_we = 1, pc_sel = 0, retire = 1 in the ack cycle.
- WB (one cycle):
  - rf_we = 1 only if rd != 0.
  - wb_sel: ALU for R/I types, MEM for LOAD, PC+4 for JAL/JALR, IMM for LUI.
  - pc_we = 1; pc_sel = 1 for JAL, 2 for JALR, else 0.
  - retire = 1, next state FETCH.
- Invariants:
  - pc_we and retire assert in exactly the same cycle, once per instruction.
  - instret increments on retire and wraps modulo 2^CNT_W.
- HALT:
  - All request and enable outputs are 0; trap = 1.
  - State is held until rst.
- Acks outside the matching request state are ignored.
- Latency with zero-wait acks: ALU/JAL/JALR = 4 cycles, LUI = 3, BRANCH = 3, STORE = 4, LOAD = 5.

Test Plan:
- Reset, then ADD x3,x1,x2 (0x002081B3) with immediate imem_ack -> IDLE, FETCH, DECODE, EXEC (alu_op = 0, alu_src_b = 0), WB (rf_we = 1, wb_sel = 0, pc_we = 1, retire = 1); instret = 1.
- LW with dmem_ack delayed 3 cycles -> dmem_req/dmem_we = 1/0 held for 4 cycles; WB has wb_sel = 1; retire at cycle 8 after FETCH entry.
- BEQ with br_cond = 1, then br_cond = 0 -> EXEC gives pc_we = 1 with pc_sel = 1, then pc_sel = 0; rf_we never asserted; instret increments by 2.
- SRAI (funct7 = 0100000, funct3 = 101) -> alu_op = 7, alu_src_b = 1. ADDI x0 -> rf_we = 0 but retire = 1.
- Opcode 0x7F -> HALT after DECODE: trap = 1, trap_cause = 1, imem_req stays 0 for 20 cycles; rst clears.
- MEM_TIMEOUT = 4 with imem_ack held low -> trap_cause = 2 after 4 cycles. Separately, assert rst during MEM -> dmem_req drops immediately, no retire.
